// File: rtl/axis_boxcar_decimator.sv
// Boxcar decimator: averages 2^N signed AXI-Stream samples into one floor-rounded mean.
// With enable low it becomes a combinational pass-through between the two streams.
module axis_boxcar_decimator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MAX_LOG2_FACTOR  = 10
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [3:0]                  log2_factor,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        S_AXIS_tready,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

  localparam int W     = AXIS_TDATA_WIDTH;
  localparam int ACC_W = AXIS_TDATA_WIDTH + MAX_LOG2_FACTOR;
  localparam int CNT_W = MAX_LOG2_FACTOR;
  localparam logic [3:0] N_MAX = 4'(MAX_LOG2_FACTOR);

  logic signed [ACC_W-1:0] r_acc;
  logic        [CNT_W-1:0] r_cnt;
  logic        [3:0]       r_n_blk;
  logic        [W-1:0]     r_out_data;
  logic                    r_out_valid;

  logic        [3:0]       w_n_clamp;
  logic        [3:0]       w_n_eff;
  logic        [CNT_W:0]   w_term;
  logic                    w_last;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_mean_full;
  logic                    w_stall;
  logic                    w_accept;

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    w_n_clamp = (log2_factor > N_MAX) ? N_MAX : log2_factor;
    // A block that has not started yet is governed by the live exponent.
    w_n_eff   = (r_cnt == '0) ? w_n_clamp : r_n_blk;
    w_term    = ((CNT_W+1)'(1) << w_n_eff) - (CNT_W+1)'(1);
    w_last    = ({1'b0, r_cnt} == w_term);

    w_sum       = r_acc + {{MAX_LOG2_FACTOR{S_AXIS_tdata[W-1]}}, S_AXIS_tdata};
    w_mean_full = w_sum >>> w_n_eff;

    // Only a block-closing sample can collide with an undrained result.
    w_stall = r_out_valid && !M_AXIS_tready && w_last;

    if (enable) begin
      S_AXIS_tready = aresetn && !w_stall;
      M_AXIS_tvalid = r_out_valid;
      M_AXIS_tdata  = r_out_data;
    end else begin
      S_AXIS_tready = aresetn && M_AXIS_tready;
      M_AXIS_tvalid = aresetn && S_AXIS_tvalid;
      M_AXIS_tdata  = S_AXIS_tdata;
    end

    w_accept = S_AXIS_tvalid && S_AXIS_tready;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_n_blk     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (!enable) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && M_AXIS_tready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (r_cnt == '0) begin
          r_n_blk <= w_n_clamp;
        end
        if (w_last) begin
          // Later assignment wins, so a same-cycle drain and reload leaves valid high.
          r_out_data  <= w_mean_full[W-1:0];
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_boxcar_decimator.sv
// Self-checking bench for axis_boxcar_decimator: directed vectors, corner sequences,
// and a randomized run scored against a block-average model.
module tb_axis_boxcar_decimator;

  localparam int W   = 32;
  localparam int MAX = 10;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          enable;
  logic [3:0]    log2_factor;
  logic          s_tvalid;
  logic [W-1:0]  s_tdata;
  logic          s_tready;
  logic          m_tready;
  logic          m_tvalid;
  logic [W-1:0]  m_tdata;

  int n_checks = 0;
  int n_errors = 0;

  axis_boxcar_decimator #(
    .AXIS_TDATA_WIDTH(W),
    .MAX_LOG2_FACTOR (MAX)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .enable       (enable),
    .log2_factor  (log2_factor),
    .S_AXIS_tvalid(s_tvalid),
    .S_AXIS_tdata (s_tdata),
    .S_AXIS_tready(s_tready),
    .M_AXIS_tready(m_tready),
    .M_AXIS_tvalid(m_tvalid),
    .M_AXIS_tdata (m_tdata)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string             name;
    logic [3:0]        n;
    int                cnt;
    logic signed [W-1:0] d [4];
    logic signed [W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Presents one sample and waits (bounded) for it to be accepted; valid stays high.
  task automatic send(input logic [W-1:0] d);
    s_tdata  = d;
    s_tvalid = 1'b1;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (s_tready) begin
        step();
        return;
      end
      step();
    end
    check("send_timeout", 0, 1);
  endtask

  function automatic int clamp_n(input logic [3:0] n);
    return (int'(n) > MAX) ? MAX : int'(n);
  endfunction

  function automatic longint floor_mean(input longint sum, input int n);
    longint d;
    longint q;
    d = longint'(1) << n;
    q = sum / d;
    if ((sum % d) != 0 && sum < 0) q = q - 1;
    return q;
  endfunction

  vec_t vecs[6];

  // Reference model state for the randomized run.
  longint blk_sum;
  int     blk_len;
  int     blk_n;
  longint exp_q[$];
  logic   prev_hold;
  logic [W-1:0] prev_data;

  initial begin
    vecs[0] = '{"n2_ramp",     4'd2, 4, '{1, 2, 3, 4}, 2};
    vecs[1] = '{"n2_negative", 4'd2, 4, '{-1, -2, -3, -4}, -3};
    vecs[2] = '{"n2_maxpos",   4'd2, 4, '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF}, 32'h7FFFFFFF};
    vecs[3] = '{"n2_maxneg",   4'd2, 4, '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000}, 32'h80000000};
    vecs[4] = '{"n1_floor",    4'd1, 2, '{5, -6, 0, 0}, -1};
    vecs[5] = '{"n0_copy",     4'd0, 1, '{-7, 0, 0, 0}, -7};

    aresetn = 1'b0; enable = 1'b1; log2_factor = 4'd2;
    s_tvalid = 1'b1; s_tdata = 32'd99; m_tready = 1'b1;
    step(); step();
    check("reset_m_tvalid", m_tvalid, 0);
    check("reset_m_tdata", m_tdata, 0);
    check("reset_s_tready", s_tready, 0);
    s_tvalid = 1'b0;
    aresetn  = 1'b1;
    step();

    // Table-driven single blocks with an always-ready sink.
    foreach (vecs[k]) begin
      log2_factor = vecs[k].n;
      for (int j = 0; j < vecs[k].cnt; j++) begin
        if (j == vecs[k].cnt - 1) check({vecs[k].name, "_early"}, m_tvalid, 0);
        send(vecs[k].d[j]);
      end
      check({vecs[k].name, "_valid"}, m_tvalid, 1);
      check({vecs[k].name, "_data"}, $signed(m_tdata), vecs[k].exp);
      s_tvalid = 1'b0;
      step();
      check({vecs[k].name, "_single"}, m_tvalid, 0);
    end

    // Backpressure: first result held, 8th sample stalls, drain and reload in one cycle.
    log2_factor = 4'd2;
    m_tready    = 1'b0;
    for (int v = 1; v <= 7; v++) send(v);
    s_tdata = 32'd8;
    s_tvalid = 1'b1;
    #1;
    check("bp_stall_tready", s_tready, 0);
    step(); step();
    check("bp_hold_valid", m_tvalid, 1);
    check("bp_hold_data", $signed(m_tdata), 2);
    m_tready = 1'b1;
    #1;
    check("bp_release_tready", s_tready, 1);
    step();
    check("bp_second_valid", m_tvalid, 1);
    check("bp_second_data", $signed(m_tdata), 6);
    s_tvalid = 1'b0;
    step();
    check("bp_drained", m_tvalid, 0);

    // Exponent change mid-block applies to the following block.
    log2_factor = 4'd1;
    send(10);
    log2_factor = 4'd0;
    send(20);
    check("nsw_mean", $signed(m_tdata), 15);
    check("nsw_mean_valid", m_tvalid, 1);
    send(33);
    check("nsw_copy_a", $signed(m_tdata), 33);
    send(-5);
    check("nsw_copy_b", $signed(m_tdata), -5);
    s_tvalid = 1'b0;
    step();

    // Bypass mode mirrors the streams combinationally.
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_tdata  = $urandom;
      s_tvalid = 1'($urandom_range(0, 1));
      m_tready = 1'($urandom_range(0, 1));
      #1;
      check("byp_tdata", m_tdata, s_tdata);
      check("byp_tvalid", m_tvalid, s_tvalid);
      check("byp_tready", s_tready, m_tready);
      step();
    end

    // Partial block is discarded across an enable drop.
    enable = 1'b1; log2_factor = 4'd2; m_tready = 1'b1; s_tvalid = 1'b0;
    step();
    send(1);
    send(2);
    s_tvalid = 1'b0;
    enable   = 1'b0;
    step();
    enable = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check("reen_early", m_tvalid, 0);
      send(4);
    end
    check("reen_early", m_tvalid, 0);
    send(4);
    check("reen_valid", m_tvalid, 1);
    check("reen_data", $signed(m_tdata), 4);
    s_tvalid = 1'b0;
    step();

    // Reset mid-block discards the partial sum.
    send(5); send(5); send(5);
    s_tdata = 32'd5; s_tvalid = 1'b1;
    aresetn = 1'b0;
    #1;
    check("rst_mid_tready", s_tready, 0);
    check("rst_mid_tvalid", m_tvalid, 0);
    step();
    check("rst_mid_tvalid_post", m_tvalid, 0);
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(8);
      check("rst_after_early", m_tvalid, 0);
    end
    send(8);
    check("rst_after_valid", m_tvalid, 1);
    check("rst_after_data", $signed(m_tdata), 8);
    s_tvalid = 1'b0;
    step(); step();

    // Randomized traffic scored against the block-average model.
    blk_sum = 0; blk_len = 0; blk_n = 0; prev_hold = 1'b0; prev_data = '0;
    log2_factor = 4'd15;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc >= 2500 && $urandom_range(0, 15) == 0) log2_factor = 4'($urandom_range(0, 4));
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = $urandom;
      m_tready = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_hold) begin
        check("rnd_hold_valid", m_tvalid, 1);
        check("rnd_hold_data", m_tdata, prev_data);
      end
      if (s_tvalid && !s_tready) begin
        int n_now;
        n_now = (blk_len == 0) ? clamp_n(log2_factor) : blk_n;
        check("rnd_stall_rule",
              (blk_len == (1 << n_now) - 1) && m_tvalid && !m_tready, 1);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("rnd_spurious_out", m_tvalid, 0);
        else check("rnd_data", $signed(m_tdata), exp_q.pop_front());
      end
      if (s_tvalid && s_tready) begin
        if (blk_len == 0) blk_n = clamp_n(log2_factor);
        blk_sum += longint'($signed(s_tdata));
        blk_len++;
        if (blk_len == (1 << blk_n)) begin
          exp_q.push_back(floor_mean(blk_sum, blk_n));
          blk_sum = 0;
          blk_len = 0;
        end
      end
      prev_hold = m_tvalid && !m_tready;
      prev_data = m_tdata;
      step();
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (m_tvalid) begin
        if (exp_q.size() == 0) check("rnd_spurious_out", m_tvalid, 0);
        else check("rnd_data", $signed(m_tdata), exp_q.pop_front());
      end
      step();
    end
    check("rnd_all_results_seen", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_boxcar_decimator.md
# axis_boxcar_decimator

Downstream consumer of the velocity differentiator output. It averages 2^N consecutive signed AXI-Stream samples and emits one mean per block, reducing the sample rate by 2^N before the data reaches DMA or the host. When `enable` is low, the block is a transparent combinational bypass.

## Interface
- `AXIS_TDATA_WIDTH`, default 32: sample width, signed two's complement, on both streams.
- `MAX_LOG2_FACTOR`, default 10: largest supported N. The accumulator width is AXIS_TDATA_WIDTH+MAX_LOG2_FACTOR.
- `aclk`  in  1: clock.
- `aresetn`  in  1: reset, synchronous, active-low.
- `enable`  in  1: 1 selects averaging, 0 selects bypass.
- `log2_factor`  in  4: N, the decimation exponent. Values above MAX_LOG2_FACTOR are clamped to MAX_LOG2_FACTOR.
- `S_AXIS_tvalid`  in  1: input sample valid.
- `S_AXIS_tdata`  in  AXIS_TDATA_WIDTH: input sample, signed.
- `S_AXIS_tready`  out  1: input accept.
- `M_AXIS_tready`  in  1: downstream accept.
- `M_AXIS_tvalid`  out  1: output valid.
- `M_AXIS_tdata`  out  AXIS_TDATA_WIDTH: output mean, signed.

## Operation
- A sample is accepted on a cycle where `S_AXIS_tvalid` and `S_AXIS_tready` are both 1.
- Internal state:
  - Signed accumulator `acc`, width AXIS_TDATA_WIDTH+MAX_LOG2_FACTOR.
  - Sample counter `cnt`, 0..2^MAX_LOG2_FACTOR-1.
  - Latched exponent `n_blk`.
  - One-deep output register `out_data`/`out_valid`.
- Block start: on an accepted sample with `cnt==0`, `n_blk` latches the clamped `log2_factor`. A change to `log2_factor` mid-block takes effect at the next block.
- Non-last sample (`cnt != 2^n_blk-1`):
  - acc <= acc + sext(tdata).
  - cnt <= cnt+1.
- Last sample:
  - out_data <= (acc + sext(tdata)) >>> n_blk, arithmetic shift, rounding toward −∞, truncated to AXIS_TDATA_WIDTH. The result always fits, so no saturation is needed.
  - out_valid <= 1.
  - acc <= 0 and cnt <= 0.
- N=0: every accepted sample is copied to the output register unchanged.
- Output drain: when `out_valid && M_AXIS_tready`, out_valid <= 0 unless a new last sample is accepted in the same cycle. In that case the register is reloaded and out_valid stays 1.
- Enabled-mode handshake:
  - S_AXIS_tready = aresetn && !(out_valid && !M_AXIS_tready && cnt==2^n_blk-1).
  - For the tready term, `n_blk` means the clamped `log2_factor` when cnt==0.
  - Non-last samples are never stalled.
- Outputs in enabled mode: M_AXIS_tvalid = out_valid, M_AXIS_tdata = out_data.
- Bypass mode (`enable`=0):
  - M_AXIS_tdata = S_AXIS_tdata, M_AXIS_tvalid = S_AXIS_tvalid, S_AXIS_tready = M_AXIS_tready && aresetn.
  - acc, cnt and out_valid are held cleared to 0.
- Enable transitions:
  - Falling `enable` discards any partial block and any pending output.
  - Rising `enable` starts a fresh block on the next accepted sample.

## Timing
- Reset, checked on the aclk edge with aresetn=0:
  - acc, cnt, n_blk, out_data and out_valid go to 0.
  - M_AXIS_tvalid=0, M_AXIS_tdata=0 (bypass shows S_AXIS_tdata), S_AXIS_tready=0.
- Reset mid-block or with a pending output discards all state. There is no flush.
- Throughput: one sample per cycle when downstream is ready.
- Latency: M_AXIS_tvalid rises one cycle after the edge that accepts the last sample of a block.
- Once asserted, M_AXIS_tvalid and M_AXIS_tdata stay stable until accepted (AXIS rule). The exception is reset or enable falling.
- Simultaneous drain and new result in one cycle: the new value appears the next cycle with no bubble.
- Bypass path is purely combinational, with zero latency.

## Test plan
- N=2, inputs 1,2,3,4, tready=1 → single output 2 (10>>>2), one cycle after the 4th accept. No other output.
- N=2, inputs −1,−2,−3,−4 → output −3 (−10>>>2 rounds toward −∞). Inputs 4× 0x7FFFFFFF → 0x7FFFFFFF, no wrap.
- N=2, 8 back-to-back samples 1..8, M_AXIS_tready=0:
  - First result 2 is held.
  - S_AXIS_tready drops on the 8th sample.
  - Raising tready drains 2, then 8th sample is accepted, then 6 is output.
- N=1 for samples 10,20, then log2_factor switched to 0 after the 1st sample → outputs 15, then each following sample passes unchanged.
- enable=0 → output mirrors input every cycle, and tready follows M_AXIS_tready. Drop enable after 2 of 4 samples, re-enable, feed 4,4,4,4 → output 4 (partial block discarded).
- aresetn low for one cycle after 3 of 4 samples (N=2) → tvalid=0 and tready=0 during reset. Next 4 samples 8,8,8,8 → output 8.
